// File: rtl/sys_pkg.sv
// Shared datapath types for the systolic-array output path.
// Partial sums are signed 32-bit; relu() serves the optional rectification stage.
package sys_pkg;

  localparam int PSUM_W     = 32;
  localparam int COL_SIZE_W = 16;

  typedef logic signed [PSUM_W-1:0] psum_t;

  function automatic psum_t relu(input psum_t v);
    return (v < 0) ? '0 : v;
  endfunction

endpackage

// File: rtl/sys_collector_sync_fifo.sv
// Single-clock FIFO holding aligned result rows; DEPTH must be a power of two >= 2.
// A push while full is ignored unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [AW:0]      count_q, count_d;
  logic             doPush, doPop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign doPop   = pop_i && !empty_o;
  assign doPush  = push_i && (!full_o || doPop);
  assign rdata_o = mem_q[rdPtr_q];

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = wrPtr_q + 1'b1;
    if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
    case ({doPush, doPop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset: the pointers alone decide what is visible.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= wdata_i;
  end

endmodule

// File: rtl/sys_collector.sv
// Deskews per-column psums from the array bottom into aligned rows and queues them for output.
// Define SYS_COLLECT_RELU_EN to clamp negative enabled lanes to zero before queuing.
module sys_collector
  import sys_pkg::*;
#(
  parameter int N          = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic signed [N-1:0][PSUM_W-1:0] sys_data_in,
  input  logic [N-1:0]                   sys_valid_in,
  input  logic [COL_SIZE_W-1:0]          col_size_in,
  input  logic                           col_size_valid_in,
  output logic signed [N-1:0][PSUM_W-1:0] out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [COL_SIZE_W-1:0]          out_row_cnt,
  output logic                           err_overflow,
  output logic                           err_skew
);

  psum_t                   dskData [N];
  logic [N-1:0]            dskValid;
  logic [COL_SIZE_W-1:0]   colSize_q, colSize_d;
  logic [N-1:0]            activeMask;
  logic                    rowValid;
  logic                    skewHit;
  logic [N-1:0][PSUM_W-1:0] rowData;
  logic [N-1:0][PSUM_W-1:0] fifoRdata;
  logic                    fifoFull, fifoEmpty;
  logic                    popping;
  logic [COL_SIZE_W-1:0]   rowCnt_q, rowCnt_d;
  logic                    errOverflow_q, errOverflow_d;
  logic                    errSkew_q, errSkew_d;

  // Column i enters i cycles after column 0, so it waits N-1-i stages to line up.
  for (genvar i = 0; i < N; i++) begin : g_col
    localparam int D = N - 1 - i;
    if (D == 0) begin : g_pass
      assign dskValid[i] = sys_valid_in[i];
      assign dskData[i]  = psum_t'(sys_data_in[i]);
    end else begin : g_dly
      logic [D-1:0] vld_q;
      psum_t        dat_q [D];
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q <= '0;
          for (int k = 0; k < D; k++) dat_q[k] <= '0;
        end else begin
          vld_q[0] <= sys_valid_in[i];
          dat_q[0] <= psum_t'(sys_data_in[i]);
          for (int k = 1; k < D; k++) begin
            vld_q[k] <= vld_q[k-1];
            dat_q[k] <= dat_q[k-1];
          end
        end
      end
      assign dskValid[i] = vld_q[D-1];
      assign dskData[i]  = dat_q[D-1];
    end
  end

  always_comb begin
    activeMask = '0;
    for (int i = 0; i < N; i++) activeMask[i] = (colSize_q > COL_SIZE_W'(i));
  end

  // A non-empty mask always contains column 0, so its bit doubles as the non-empty test.
  assign rowValid = dskValid[0] && activeMask[0];
  assign skewHit  = |((dskValid ^ {N{dskValid[0]}}) & activeMask);

  always_comb begin
    rowData = '0;
    for (int i = 0; i < N; i++) begin
`ifdef SYS_COLLECT_RELU_EN
      if (activeMask[i]) rowData[i] = relu(dskData[i]);
`else
      if (activeMask[i]) rowData[i] = dskData[i];
`endif
    end
  end

  sync_fifo #(
    .WIDTH (N*PSUM_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rowValid),
    .wdata_i (rowData),
    .pop_i   (popping),
    .rdata_o (fifoRdata),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  assign out_valid = !fifoEmpty;
  assign popping   = out_valid && out_ready;
  assign out_data  = out_valid ? fifoRdata : '0;

  always_comb begin
    colSize_d     = col_size_valid_in ? col_size_in : colSize_q;
    rowCnt_d      = rowCnt_q + COL_SIZE_W'(popping);
    errOverflow_d = errOverflow_q | (rowValid && fifoFull && !popping);
    errSkew_d     = errSkew_q | skewHit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      colSize_q     <= COL_SIZE_W'(N);
      rowCnt_q      <= '0;
      errOverflow_q <= 1'b0;
      errSkew_q     <= 1'b0;
    end else begin
      colSize_q     <= colSize_d;
      rowCnt_q      <= rowCnt_d;
      errOverflow_q <= errOverflow_d;
      errSkew_q     <= errSkew_d;
    end
  end

  assign out_row_cnt  = rowCnt_q;
  assign err_overflow = errOverflow_q;
  assign err_skew     = errSkew_q;

endmodule

// File: tb/tb_sys_collector.sv
// Scoreboard bench for sys_collector at N=2, FIFO_DEPTH=4.
// Expected rows are queued as stimulus is driven and retired by a negedge monitor.
module tb_sys_collector;

  logic             clk;
  logic             rst;
  logic [1:0][31:0] dataIn;
  logic [1:0]       validIn;
  logic [15:0]      colSizeIn;
  logic             colSizeValid;
  logic [1:0][31:0] outData;
  logic             outValid;
  logic             outReady;
  logic [15:0]      outRowCnt;
  logic             errOverflow;
  logic             errSkew;

  int          vectorCount = 0;
  int          missCount   = 0;
  int          curColSize  = 2;
  logic [63:0] sbQ [$];
  logic [15:0] expRowCnt   = '0;

  sys_collector #(.N(2), .FIFO_DEPTH(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .sys_data_in       (dataIn),
    .sys_valid_in      (validIn),
    .col_size_in       (colSizeIn),
    .col_size_valid_in (colSizeValid),
    .out_data          (outData),
    .out_valid         (outValid),
    .out_ready         (outReady),
    .out_row_cnt       (outRowCnt),
    .err_overflow      (errOverflow),
    .err_skew          (errSkew)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] expRow(input logic signed [31:0] a, input logic signed [31:0] b, input int cs);
    logic signed [31:0] l0, l1;
    l0 = (cs >= 1) ? a : 32'sd0;
    l1 = (cs >= 2) ? b : 32'sd0;
`ifdef SYS_COLLECT_RELU_EN
    if (l0 < 0) l0 = 32'sd0;
    if (l1 < 0) l1 = 32'sd0;
`endif
    return {l1, l0};
  endfunction

  // Retire one expected row per observed transfer, and track the transfer count.
  always @(negedge clk) begin
    if (rst) begin
      expRowCnt = '0;
    end else if (outValid && outReady) begin
      if (sbQ.size() == 0) begin
        checkOutput("spurious row", {63'b0, outValid}, 64'd0);
      end else begin
        checkOutput("row data", outData, sbQ.pop_front());
        checkOutput("row count", {48'b0, outRowCnt}, {48'b0, expRowCnt});
      end
      expRowCnt = expRowCnt + 16'd1;
    end
  end

  task automatic doReset();
    @(posedge clk); #1;
    rst = 1'b1;
    validIn = '0;
    colSizeValid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sbQ.delete();
    rst = 1'b0;
    curColSize = 2;
  endtask

  task automatic loadColSize(input int cs);
    @(posedge clk); #1;
    colSizeIn = 16'(cs);
    colSizeValid = 1'b1;
    @(posedge clk); #1;
    colSizeValid = 1'b0;
    curColSize = cs;
  endtask

  task automatic driveRow(input logic signed [31:0] a, input logic signed [31:0] b);
    @(posedge clk); #1;
    validIn = 2'b01; dataIn[0] = a; dataIn[1] = '0;
    sbQ.push_back(expRow(a, b, curColSize));
    @(posedge clk); #1;
    validIn = 2'b10; dataIn[0] = '0; dataIn[1] = b;
    @(posedge clk); #1;
    validIn = '0;
  endtask

  // Back-to-back skewed rows; only the first 'keep' rows are expected to survive.
  task automatic streamRows(input int rows, input int keep);
    logic signed [31:0] a [$];
    logic signed [31:0] b [$];
    for (int k = 0; k < rows; k++) begin
      a.push_back(32'($urandom_range(0, 2000)) - 32'sd1000);
      b.push_back(32'($urandom_range(0, 2000)) - 32'sd1000);
    end
    for (int k = 0; k <= rows; k++) begin
      @(posedge clk); #1;
      validIn[0] = (k < rows);
      dataIn[0]  = (k < rows) ? a[k] : '0;
      validIn[1] = (k > 0);
      dataIn[1]  = (k > 0) ? b[k-1] : '0;
      if (k < keep) sbQ.push_back(expRow(a[k], b[k], curColSize));
    end
    @(posedge clk); #1;
    validIn = '0;
  endtask

  task automatic waitDrain(input int budget);
    int c = 0;
    while (sbQ.size() != 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    checkOutput("drain left", 64'(sbQ.size()), 64'd0);
    @(negedge clk);
    checkOutput("idle valid", {63'b0, outValid}, 64'd0);
  endtask

  task automatic applyStimulus();
    // Reset values
    doReset();
    @(negedge clk);
    checkOutput("rst out_valid", {63'b0, outValid}, 64'd0);
    checkOutput("rst out_data", outData, 64'd0);
    checkOutput("rst row_cnt", {48'b0, outRowCnt}, 64'd0);
    checkOutput("rst overflow", {63'b0, errOverflow}, 64'd0);
    checkOutput("rst skew", {63'b0, errSkew}, 64'd0);

    // Basic row {-7,5} with latency t+2, using the reset column size
    outReady = 1'b1;
    @(posedge clk); #1;
    validIn = 2'b01; dataIn[0] = 32'd5; dataIn[1] = '0;
    sbQ.push_back(expRow(32'sd5, -32'sd7, curColSize));
    @(negedge clk);
    checkOutput("lat t", {63'b0, outValid}, 64'd0);
    @(posedge clk); #1;
    validIn = 2'b10; dataIn[0] = '0; dataIn[1] = -32'sd7;
    @(negedge clk);
    checkOutput("lat t+1", {63'b0, outValid}, 64'd0);
    @(posedge clk); #1;
    validIn = '0;
    @(negedge clk);
    checkOutput("lat t+2", {63'b0, outValid}, 64'd1);
    checkOutput("row -7/5", outData, 64'hFFFFFFF9_00000005);
    @(negedge clk);
    checkOutput("cnt after 1", {48'b0, outRowCnt}, 64'd1);

    // One active column: lane 1 forced to zero, its stray valid ignored
    loadColSize(1);
    @(posedge clk); #1;
    validIn = 2'b11; dataIn[0] = 32'd9; dataIn[1] = 32'd55;
    sbQ.push_back(expRow(32'sd9, 32'sd123, curColSize));
    @(posedge clk); #1;
    validIn = 2'b00; dataIn[0] = '0; dataIn[1] = 32'd123;
    @(posedge clk); #1;
    validIn = '0;
    @(negedge clk);
    checkOutput("cs1 valid", {63'b0, outValid}, 64'd1);
    checkOutput("cs1 row", outData, 64'h00000000_00000009);
    checkOutput("cs1 skew", {63'b0, errSkew}, 64'd0);
    loadColSize(2);

    // Negative lane
    driveRow(-32'sd3, 32'sd4);
    @(negedge clk);
`ifdef SYS_COLLECT_RELU_EN
    checkOutput("neg lane", outData, 64'h00000004_00000000);
`else
    checkOutput("neg lane", outData, 64'h00000004_FFFFFFFD);
`endif
    waitDrain(10);

    // Sustained one row per cycle
    streamRows(6, 6);
    waitDrain(3);

    // Column 1 one cycle late: sticky skew error
    @(posedge clk); #1;
    validIn = 2'b01; dataIn[0] = 32'd21; dataIn[1] = '0;
    sbQ.push_back(expRow(32'sd21, 32'sd0, curColSize));
    @(posedge clk); #1;
    validIn = 2'b00; dataIn[0] = '0;
    @(posedge clk); #1;
    validIn = 2'b10; dataIn[1] = 32'd77;
    @(posedge clk); #1;
    validIn = '0; dataIn[1] = '0;
    @(negedge clk);
    checkOutput("skew set", {63'b0, errSkew}, 64'd1);
    streamRows(2, 2);
    waitDrain(10);
    checkOutput("skew sticky", {63'b0, errSkew}, 64'd1);

    // Reset clears sticky errors
    doReset();
    @(negedge clk);
    checkOutput("skew cleared", {63'b0, errSkew}, 64'd0);

    // Overflow: fifth row dropped while stalled, first four retained in order
    outReady = 1'b0;
    streamRows(4, 4);
    repeat (2) @(negedge clk);
    checkOutput("full valid", {63'b0, outValid}, 64'd1);
    checkOutput("no ovf yet", {63'b0, errOverflow}, 64'd0);
    checkOutput("stall hold a", outData, sbQ[0]);
    streamRows(1, 0);
    @(negedge clk);
    checkOutput("ovf set", {63'b0, errOverflow}, 64'd1);
    checkOutput("stall hold b", outData, sbQ[0]);
    checkOutput("held rows", 64'(sbQ.size()), 64'd4);
    @(posedge clk); #1;
    outReady = 1'b1;
    waitDrain(10);

    // Push into a full FIFO in the same cycle as a pop is accepted
    doReset();
    outReady = 1'b0;
    streamRows(4, 4);
    @(posedge clk); #1;
    validIn = 2'b01; dataIn[0] = 32'd31;
    sbQ.push_back(expRow(32'sd31, 32'sd32, curColSize));
    @(posedge clk); #1;
    validIn = 2'b10; dataIn[0] = '0; dataIn[1] = 32'd32;
    outReady = 1'b1;
    @(posedge clk); #1;
    validIn = '0;
    waitDrain(12);
    checkOutput("full+pop ovf", {63'b0, errOverflow}, 64'd0);

    // Reset with rows queued discards them
    outReady = 1'b0;
    streamRows(2, 2);
    repeat (2) @(negedge clk);
    checkOutput("queued valid", {63'b0, outValid}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("mid-rst valid", {63'b0, outValid}, 64'd0);
    checkOutput("mid-rst cnt", {48'b0, outRowCnt}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    sbQ.delete();
    outReady = 1'b1;
    @(negedge clk);
    checkOutput("post-rst valid", {63'b0, outValid}, 64'd0);
    repeat (6) @(negedge clk);
    checkOutput("no stale row", {63'b0, outValid}, 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    dataIn = '0;
    validIn = '0;
    colSizeIn = '0;
    colSizeValid = 1'b0;
    outReady = 1'b0;
    applyStimulus();
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/sys_collector.md
SYS_COLLECTOR -- requirements
Module: sys_collector

Interface
REQ-001 SHALL have parameter N, default 2, meaning array dimension (columns collected).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning aligned-row FIFO entries (power of two, at least 2).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-005 SHALL have port sys_data_in, input, [N-1:0][31:0] signed, meaning skewed psum per column from the array bottom.
REQ-006 SHALL have port sys_valid_in, input, [N-1:0], meaning per-column psum valid (skewed).
REQ-007 SHALL have port col_size_in, input, 16, meaning active column count.
REQ-008 SHALL have port col_size_valid_in, input, 1, meaning load col_size_in.
REQ-009 SHALL have port out_data, output, [N-1:0][31:0] signed, meaning one deskewed result row.
REQ-010 SHALL have port out_valid, output, 1, meaning out_data holds a row.
REQ-011 SHALL have port out_ready, input, 1, meaning consumer accepts the row; transfer when out_valid and out_ready.
REQ-012 SHALL have port out_row_cnt, output, 16, meaning rows transferred since reset; wraps 0xFFFF to 0.
REQ-013 SHALL have port err_overflow, output, 1, meaning sticky: row dropped on full FIFO.
REQ-014 SHALL have port err_skew, output, 1, meaning sticky: enabled columns misaligned after deskew.

Function
REQ-015 SHALL delay column i (data and valid) by N-1-i registered stages; column N-1 passes undelayed.
REQ-016 SHALL form the active mask as (1<<min(col_size,N))-1; col_size 0 gives an empty mask.
REQ-017 SHALL form an aligned row when deskewed valid of the lowest enabled column (column 0) is high and the mask is non-empty.
REQ-018 SHALL force out_data lanes of disabled columns to zero.
REQ-019 SHALL set err_skew when any enabled column's deskewed valid differs from column 0's deskewed valid in the same cycle; disabled columns are ignored.
REQ-020 SHALL push the aligned row into the FIFO in the cycle it forms; with an empty FIFO, column-0 valid in cycle t gives out_valid in cycle t+N.
REQ-021 SHALL, on push when FIFO full and no pop in the same cycle, drop the row, keep FIFO contents, and set err_overflow.
REQ-022 SHALL accept push when full if a pop occurs in the same cycle; count unchanged.
REQ-023 SHALL hold out_data stable while out_valid is high and out_ready is low.
REQ-024 SHALL sustain one row per cycle when out_ready stays high.
REQ-025 SHALL increment out_row_cnt by one per transfer.
REQ-026 SHALL apply a col_size load from the next cycle; rows already in the FIFO are unaffected.

Reset
REQ-027 SHALL, on rst, clear delay lines, FIFO pointers and count, out_valid=0, out_data=0, out_row_cnt=0, err_overflow=0, err_skew=0, col_size=N.
REQ-028 SHALL discard in-flight and queued rows when rst asserts mid-stream; no row is emitted in the first cycle after reset release.

Configuration
REQ-029 SHALL, with SYS_COLLECT_RELU_EN defined, replace negative enabled lanes with zero before the FIFO push.
REQ-030 SHALL, without SYS_COLLECT_RELU_EN, pass psums unmodified.

Structure
REQ-031 SHALL take psum_t (signed 32-bit) and PSUM_W=32 from shared package sys_pkg.
REQ-032 SHALL implement the FIFO as sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty).

Verification
REQ-033 SHALL cover: N=2, col_size=2, col0=5 at t and col1=-7 at t+1 -> out_valid at t+2 with out_data {-7,5}; out_row_cnt=1.
REQ-034 SHALL cover: N=2, col_size=1, col0=9 at t -> row {0,9} at t+2; col1 valid ignored; err_skew=0.
REQ-035 SHALL cover: out_ready=0 with 5 rows pushed and FIFO_DEPTH=4 -> 4 rows held, err_overflow=1; then out_ready=1 -> first 4 rows in order.
REQ-036 SHALL cover: col1 valid one cycle late with col_size=2 -> err_skew=1 and stays 1 until rst.
REQ-037 SHALL cover: input -3 in an enabled lane -> output 0 with SYS_COLLECT_RELU_EN, -3 without.
REQ-038 SHALL cover: rst asserted with 2 rows queued -> out_valid=0 next cycle, out_row_cnt=0, no stale row emitted afterwards.
